// File: rtl/lstm_gate_preact_gen.sv
// LSTM gate pre-activation engine: fgio_out[r] = b[r] + sum_c W[r][c] * h_prev[c]
// in signed Q(32-FRAC).FRAC, one streamed weight/bias word consumed per accepted handshake.
module lstm_gate_preact_gen #(
    parameter int ROWS = 400,
    parameter int COLS = 100,
    parameter int FRAC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] h_prev   [COLS],
    input  logic signed [31:0] w_data,
    input  logic               w_valid,
    output logic               w_ready,
    output logic signed [31:0] fgio_out [ROWS],
    output logic               out_valid,
    output logic               done,
    output logic               busy
);

    localparam int DATA_W = 32;
    localparam int ACC_W  = 64;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BIAS  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 64'sd2147483647;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -64'sd2147483648;

    // Clamp a 64-bit value into the signed 32-bit range.
    function automatic logic signed [DATA_W-1:0] sat32(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return 32'sh7FFF_FFFF;
        end else if (v < SAT_MIN) begin
            return 32'sh8000_0000;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    // Drop the fractional bits with an arithmetic shift (floor), then saturate.
    function automatic logic signed [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shr;
        shr = acc >>> FRAC;
        return sat32(shr);
    endfunction

    logic [2:0]               state_q, state_d;
    logic [RW-1:0]            row_q, row_d;
    logic [CW-1:0]            col_q, col_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] h_q    [COLS];
    logic signed [DATA_W-1:0] fgio_q [ROWS];
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  bias_ext;

    assign prod     = ACC_W'(w_data) * ACC_W'(h_q[col_q]);
    assign bias_ext = ACC_W'(w_data) <<< FRAC;

    assign w_ready   = (state_q == S_BIAS) || (state_q == S_MAC);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign fgio_out  = fgio_q;

    // Next-state, counter and accumulator logic; w_valid low simply holds BIAS/MAC.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    out_valid_d = 1'b0;
                    row_d       = '0;
                    col_d       = '0;
                    state_d     = S_BIAS;
                end
            end
            S_BIAS: begin
                if (w_valid) begin
                    acc_d   = bias_ext;
                    col_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (w_valid) begin
                    acc_d = acc_q + prod;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (row_q == ROW_LAST) begin
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = S_BIAS;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, counters and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Private copy of h_prev taken on the accepted start so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            for (int c = 0; c < COLS; c++) begin
                h_q[c] <= h_prev[c];
            end
        end
    end

    // Result array: one row written per WRITE cycle, untouched rows keep old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                fgio_q[r] <= '0;
            end
        end else if (state_q == S_WRITE) begin
            fgio_q[row_q] <= requant(acc_q);
        end
    end

endmodule

// File: tb/tb_lstm_gate_preact_gen.sv
// Directed bench for lstm_gate_preact_gen with a small 3x2 configuration.
module tb_lstm_gate_preact_gen;

    localparam int ROWS = 3;
    localparam int COLS = 2;
    localparam int FRAC = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [31:0] h_prev   [COLS];
    logic signed [31:0] w_data;
    logic               w_valid;
    logic               w_ready;
    logic signed [31:0] fgio_out [ROWS];
    logic               out_valid;
    logic               done;
    logic               busy;

    logic [31:0] stream [9];
    int          nvec = 0;
    int          nerr = 0;
    int          lat;
    logic        probe_rdy, rdy_done, ov_done, busy_done, ov_k5;
    logic [31:0] fg0_k5, fg2_k5;

    lstm_gate_preact_gen #(.ROWS(ROWS), .COLS(COLS), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .h_prev    (h_prev),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .fgio_out  (fgio_out),
        .out_valid (out_valid),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rows(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2);
        check({tag, "_r0"}, fgio_out[0], e0);
        check({tag, "_r1"}, fgio_out[1], e1);
        check({tag, "_r2"}, fgio_out[2], e2);
    endtask

    task automatic load(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
                        input logic [31:0] a6, input logic [31:0] a7, input logic [31:0] a8);
        stream[0] = a0; stream[1] = a1; stream[2] = a2;
        stream[3] = a3; stream[4] = a4; stream[5] = a5;
        stream[6] = a6; stream[7] = a7; stream[8] = a8;
    endtask

    // Start in cycle T (k=0), then feed the stream; lat = k of the done pulse, -1 if never seen.
    task automatic run(input bit stall, input bit poke, input int abort_k, input int probe_k);
        int idx;
        int k;
        bit seen;
        bit aborted;
        bit hs;
        idx = 0; seen = 0; aborted = 0; lat = -1;
        start = 1'b1; w_valid = 1'b0; w_data = '0;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        while (!seen && !aborted && k < 200) begin
            if (poke && k == 1) begin
                h_prev[0] = 32'h0003_0000;
                h_prev[1] = 32'h0004_0000;
            end
            start   = poke && (k == 3);
            rst     = (k == abort_k);
            w_valid = (idx < 9) && (!stall || (k % 2 == 0));
            w_data  = (idx < 9) ? stream[idx] : 32'h0;
            @(negedge clk);
            if (k == probe_k) probe_rdy = w_ready;
            if (k == 5) begin
                ov_k5  = out_valid;
                fg0_k5 = fgio_out[0];
                fg2_k5 = fgio_out[2];
            end
            if (done) begin
                seen = 1; lat = k;
                rdy_done = w_ready; ov_done = out_valid; busy_done = busy;
            end
            hs = w_valid && w_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            if (rst) begin
                rst = 1'b0;
                aborted = 1;
            end
            k++;
        end
        start = 1'b0;
        w_valid = 1'b0;
    endtask

    // Checks for the cycle after a completed run, plus hold of out_valid.
    task automatic after_done(input string tag, input int exp_lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ready_in_done"}, 32'(rdy_done), 32'd0);
        check({tag, "_ov_in_done"}, 32'(ov_done), 32'd1);
        check({tag, "_busy_in_done"}, 32'(busy_done), 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_ready_idle"}, 32'(w_ready), 32'd0);
        check({tag, "_ov_held"}, 32'(out_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; w_valid = 1'b0; w_data = '0;
        h_prev[0] = '0; h_prev[1] = '0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(w_ready), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_rows("rst_out", 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic 3x2 case, w_valid held high
        h_prev[0] = 32'h0001_0000; h_prev[1] = 32'h0002_0000;
        load(32'h0000_8000, 32'h0001_0000, 32'h0001_0000,
             32'h0000_0000, 32'hFFFF_0000, 32'h0000_8000,
             32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_0000);
        run(0, 0, 0, 4);
        check("s1_ready_in_write", 32'(probe_rdy), 32'd0);
        after_done("s1", 13);
        check_rows("s1_out", 32'h0003_8000, 32'h0000_0000, 32'h7FFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("s1_ov_still", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // Negative saturation in row 0, plain values in rows 1 and 2
        h_prev[0] = 32'h7FFF_0000; h_prev[1] = 32'h0000_0000;
        load(32'h8000_0000, 32'h8000_0000, 32'h0000_0000,
             32'h0001_0000, 32'h0000_0000, 32'h0000_0000,
             32'hFFFF_0000, 32'h0001_0000, 32'h7FFF_FFFF);
        run(0, 0, 0, 0);
        after_done("s3", 13);
        check_rows("s3_out", 32'h8000_0000, 32'h0001_0000, 32'h7FFE_0000);

        // Backpressure: w_valid only on even cycles after start, 7 stall cycles in total
        h_prev[0] = 32'h0001_0000; h_prev[1] = 32'h0002_0000;
        load(32'h0000_8000, 32'h0001_0000, 32'h0001_0000,
             32'h0000_0000, 32'hFFFF_0000, 32'h0000_8000,
             32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_0000);
        run(1, 0, 0, 7);
        check("s4_ready_in_write", 32'(probe_rdy), 32'd0);
        after_done("s4", 20);
        check_rows("s4_out", 32'h0003_8000, 32'h0000_0000, 32'h7FFF_FFFF);

        // h_prev changed after start, start pulsed while busy
        h_prev[0] = 32'h0001_0000; h_prev[1] = 32'h0002_0000;
        run(0, 1, 0, 4);
        check("s5_ready_in_write", 32'(probe_rdy), 32'd0);
        after_done("s5", 13);
        check_rows("s5_out", 32'h0003_8000, 32'h0000_0000, 32'h7FFF_FFFF);

        // Floor rounding of negative fractions
        h_prev[0] = 32'h0000_8000; h_prev[1] = 32'h0000_0000;
        load(32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
             32'h0000_0000, 32'h0000_0001, 32'h0000_0000,
             32'h0000_0001, 32'h0000_0003, 32'h1234_5678);
        run(0, 0, 0, 0);
        after_done("s3b", 13);
        check_rows("s3b_out", 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0002);

        // Reset during row 1 MAC, then a fresh full run
        h_prev[0] = 32'h0001_0000; h_prev[1] = 32'h0002_0000;
        load(32'h0000_8000, 32'h0001_0000, 32'h0001_0000,
             32'h0000_0000, 32'hFFFF_0000, 32'h0000_8000,
             32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_0000);
        run(0, 0, 6, 4);
        check("s6_ov_cleared_by_start", 32'(ov_k5), 32'd0);
        check("s6_row0_written", fg0_k5, 32'h0003_8000);
        check("s6_row2_kept", fg2_k5, 32'h0000_0002);
        check("s6_no_done", 32'(lat), 32'hFFFF_FFFF);
        @(negedge clk);
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_ov", 32'(out_valid), 32'd0);
        check("s6_ready", 32'(w_ready), 32'd0);
        check_rows("s6_out", 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        run(0, 0, 0, 4);
        after_done("s6b", 13);
        check_rows("s6b_out", 32'h0003_8000, 32'h0000_0000, 32'h7FFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
